// File: rtl/vote_pkg.sv
// Shared types and constants for the 4-voter session controller and classifier.
package vote_pkg;

    localparam int NUM_VOTERS = 4;

    localparam logic [2:0] DEC_LOW  = 3'b100;
    localparam logic [2:0] DEC_TIE  = 3'b010;
    localparam logic [2:0] DEC_HIGH = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DECIDE,
        RESULT
    } state_t;

    function automatic logic [2:0] popcount(input logic [NUM_VOTERS-1:0] bits);
        logic [2:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
            cnt = cnt + 3'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/vote_classify.sv
// Combinational ballot classifier: 0-1 yes -> low, 2 -> tie, 3-4 -> high.
module vote_classify
    import vote_pkg::*;
(
    input  logic [NUM_VOTERS-1:0] ballot,
    output logic [2:0]            dec
);

    logic [2:0] yes_cnt;

    always_comb begin
        yes_cnt = popcount(ballot);
        if (yes_cnt <= 3'd1) begin
            dec = DEC_LOW;
        end else if (yes_cnt == 3'd2) begin
            dec = DEC_TIE;
        end else begin
            dec = DEC_HIGH;
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session sequencer: collect one vote per voter, close on all-voted or
// timeout, classify and strobe a one-hot decision. TIE_REVOTE_EN enables tie re-votes.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_REVOTES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [NUM_VOTERS-1:0] vote_valid_i,
    input  logic [NUM_VOTERS-1:0] vote_bit_i,
    output logic [NUM_VOTERS-1:0] vote_ready_o,
    output logic                  busy_o,
    output logic                  dec_valid_o,
    output logic [2:0]            dec_o,
    output logic                  timeout_o,
    output logic [1:0]            round_o
);

    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef TIE_REVOTE_EN
    localparam bit REVOTE_EN = 1'b1;
`else
    localparam bit REVOTE_EN = 1'b0;
`endif

    state_t                  state;
    logic [NUM_VOTERS-1:0]   ballot;
    logic [NUM_VOTERS-1:0]   voted;
    logic [TW-1:0]           timer;
    logic [1:0]              round;
    logic                    timed_out;
    logic [NUM_VOTERS-1:0]   accept;
    logic [NUM_VOTERS-1:0]   voted_next;
    logic [2:0]              cls_dec;
    logic                    revote_ok;

    vote_classify u_classify (
        .ballot (ballot),
        .dec    (cls_dec)
    );

    assign vote_ready_o = (state == COLLECT) ? ~voted : '0;
    assign busy_o       = (state != IDLE);
    assign accept       = vote_valid_i & vote_ready_o;
    assign voted_next   = voted | accept;
    assign revote_ok    = REVOTE_EN && (round < 2'(MAX_REVOTES));

`ifdef TIE_REVOTE_EN
    assign round_o = round;
`else
    assign round_o = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ballot      <= '0;
            voted       <= '0;
            timer       <= '0;
            round       <= '0;
            timed_out   <= 1'b0;
            dec_valid_o <= 1'b0;
            dec_o       <= '0;
            timeout_o   <= 1'b0;
        end else begin
            dec_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= COLLECT;
                        ballot    <= '0;
                        voted     <= '0;
                        timer     <= '0;
                        round     <= '0;
                        timed_out <= 1'b0;
                        dec_o     <= '0;
                        timeout_o <= 1'b0;
                    end
                end
                COLLECT: begin
                    ballot <= (ballot & ~accept) | (vote_bit_i & accept);
                    voted  <= voted_next;
                    // A full mask wins over expiry in the same cycle, so no timeout flag.
                    if (voted_next == '1) begin
                        state     <= DECIDE;
                        timed_out <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        state     <= DECIDE;
                        timed_out <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DECIDE: begin
                    if ((cls_dec == DEC_TIE) && revote_ok) begin
                        state  <= COLLECT;
                        ballot <= '0;
                        voted  <= '0;
                        timer  <= '0;
                        round  <= round + 2'd1;
                    end else begin
                        state       <= RESULT;
                        dec_valid_o <= 1'b1;
                        dec_o       <= cls_dec;
                        timeout_o   <= timed_out;
                    end
                end
                RESULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench for vote_session_ctrl; expectations adapt to TIE_REVOTE_EN.
module tb_vote_session_ctrl;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [3:0] vote_valid_i;
    logic [3:0] vote_bit_i;
    logic [3:0] vote_ready_o;
    logic       busy_o;
    logic       dec_valid_o;
    logic [2:0] dec_o;
    logic       timeout_o;
    logic [1:0] round_o;

    typedef struct {
        logic [2:0]  dec;
        logic        to;
        logic [1:0]  rnd;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned errors;
    int unsigned checks;

    vote_session_ctrl #(
        .TIMEOUT_CYCLES (16),
        .MAX_REVOTES    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .vote_valid_i (vote_valid_i),
        .vote_bit_i   (vote_bit_i),
        .vote_ready_o (vote_ready_o),
        .busy_o       (busy_o),
        .dec_valid_o  (dec_valid_o),
        .dec_o        (dec_o),
        .timeout_o    (timeout_o),
        .round_o      (round_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] dec, input logic to, input logic [1:0] rnd,
                            input int unsigned lat);
        exp_t e;
        e.dec = dec;
        e.to  = to;
        e.rnd = rnd;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic start_session();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic vote(input logic [3:0] v, input logic [3:0] b);
        vote_valid_i = v;
        vote_bit_i   = b;
        tick();
        vote_valid_i = '0;
        vote_bit_i   = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb.size() != 0 || busy_o); i++) tick();
        check_eq("drain_busy", busy_o, 0);
        check_eq("drain_sb", sb.size(), 0);
    endtask

    // Decision monitor: every strobe must match the oldest expected result.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (dec_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_strobe", dec_valid_o, 0);
            end else begin
                e = sb.pop_front();
                check_eq("dec_o", dec_o, e.dec);
                check_eq("timeout_o", timeout_o, e.to);
                check_eq("round_o", round_o, e.rnd);
                check_eq("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        start_i      = 1'b0;
        vote_valid_i = '0;
        vote_bit_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_ready", vote_ready_o, 0);
        check_eq("rst_dec_valid", dec_valid_o, 0);
        check_eq("rst_dec", dec_o, 0);
        check_eq("rst_timeout", timeout_o, 0);
        check_eq("rst_round", round_o, 0);
        rst = 1'b0;
        tick();

        // All four vote at once, 1011 -> high
        start_session();
        check_eq("t1_ready", vote_ready_o, 4'b1111);
        check_eq("t1_busy", busy_o, 1);
        push_exp(3'b001, 1'b0, 2'd0, 2);
        vote(4'b1111, 4'b1011);
        check_eq("t1_ready_decide", vote_ready_o, 4'b0000);
        drain();

        // Staggered votes; voted voters keep offering 1 which must be ignored
        start_session();
        vote(4'b0001, 4'b0000);
        check_eq("t2_ready1", vote_ready_o, 4'b1110);
        vote(4'b0011, 4'b0001);
        check_eq("t2_ready2", vote_ready_o, 4'b1100);
        vote(4'b0111, 4'b0011);
        check_eq("t2_ready3", vote_ready_o, 4'b1000);
        push_exp(3'b100, 1'b0, 2'd0, 2);
        vote(4'b1111, 4'b0111);
        drain();

        // Only voters 0,1 vote; window closes on timeout 17 cycles later
        start_session();
`ifdef TIE_REVOTE_EN
        push_exp(3'b100, 1'b1, 2'd0, 17);
        vote(4'b0011, 4'b0001);
`else
        push_exp(3'b010, 1'b1, 2'd0, 17);
        vote(4'b0011, 4'b0011);
`endif
        check_eq("t3_ready", vote_ready_o, 4'b1100);
        repeat (10) tick();
        check_eq("t3_busy_mid", busy_o, 1);
        drain();

`ifdef TIE_REVOTE_EN
        // Tie then re-vote to high
        start_session();
        vote(4'b1111, 4'b0101);
        tick();
        check_eq("t4_ready_revote", vote_ready_o, 4'b1111);
        check_eq("t4_round1", round_o, 2'd1);
        push_exp(3'b001, 1'b0, 2'd1, 2);
        vote(4'b1111, 4'b1110);
        drain();

        // Three ties -> reported as tie after MAX_REVOTES rounds
        start_session();
        vote(4'b1111, 4'b0011);
        tick();
        check_eq("t4b_round1", round_o, 2'd1);
        vote(4'b1111, 4'b1100);
        tick();
        check_eq("t4b_round2", round_o, 2'd2);
        check_eq("t4b_ready", vote_ready_o, 4'b1111);
        push_exp(3'b010, 1'b0, 2'd2, 2);
        vote(4'b1111, 4'b0110);
        drain();
`endif

        // Asynchronous reset mid-COLLECT discards the session
        start_session();
        vote(4'b0001, 4'b0001);
        check_eq("t5_ready_pre", vote_ready_o, 4'b1110);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_busy", busy_o, 0);
        check_eq("t5_ready", vote_ready_o, 0);
        check_eq("t5_dec_valid", dec_valid_o, 0);
        check_eq("t5_dec", dec_o, 0);
        check_eq("t5_timeout", timeout_o, 0);
        check_eq("t5_round", round_o, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        start_session();
        check_eq("t5_ready_clean", vote_ready_o, 4'b1111);
        push_exp(3'b001, 1'b0, 2'd0, 2);
        vote(4'b1111, 4'b0111);
        drain();

        // start_i held through the session is ignored; vote in expiry cycle counts
        start_session();
        start_i = 1'b1;
        vote(4'b0111, 4'b0111);
        check_eq("t6_ready", vote_ready_o, 4'b1000);
        repeat (14) tick();
        check_eq("t6_busy_late", busy_o, 1);
        check_eq("t6_ready_late", vote_ready_o, 4'b1000);
        push_exp(3'b001, 1'b0, 2'd0, 2);
        vote(4'b1000, 4'b0000);
        tick();
        tick();
        check_eq("t6_idle_busy", busy_o, 0);
        check_eq("t6_dec_held", dec_o, 3'b001);
        tick();
        start_i = 1'b0;
        check_eq("t6_restart_busy", busy_o, 1);
        check_eq("t6_restart_dec", dec_o, 3'b000);
        check_eq("t6_restart_ready", vote_ready_o, 4'b1111);
        push_exp(3'b100, 1'b0, 2'd0, 2);
        vote(4'b1111, 4'b0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
